// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared image geometry, state encoding and address helper
// Purpose : constants and types shared by the pixel transmitter, its bus
//           interface and its frame buffer.
// Ports   : none (package)
package npu_pkg;

    localparam int IMG_WIDTH  = 32;
    localparam int IMG_HEIGHT = 32;
    localparam int PIX_W      = 8;
    localparam int NPIX       = IMG_WIDTH * IMG_HEIGHT;
    localparam int ADDR_W     = $clog2(NPIX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } tx_state_t;

    // A linear address is legal only when it lands inside the frame. With a
    // power-of-two frame every encodable address is legal, but the check is
    // kept so other geometries stay safe.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < (ADDR_W+1)'(NPIX));
    endfunction

endpackage

// File: rtl/image_stream_tx_if.sv
// rtl/image_stream_tx_if.sv - host write / extractor stream bundle
// Purpose : groups the host frame-buffer write port, the go request, the
//           status outputs and the pixel stream towards the extractor.
// Signals : wr_en/wr_addr/wr_data/go  host -> transmitter
//           start_signal/pixel_valid_in/pixel_in  transmitter -> extractor
//           busy/frame_done/wr_err  transmitter -> host
// Modports: master = host/extractor side, slave = transmitter
interface image_stream_tx_if;
    import npu_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              go;
    logic              start_signal;
    logic              pixel_valid_in;
    logic [PIX_W-1:0]  pixel_in;
    logic              busy;
    logic              frame_done;
    logic              wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, go,
        input  start_signal, pixel_valid_in, pixel_in, busy, frame_done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, go,
        output start_signal, pixel_valid_in, pixel_in, busy, frame_done, wr_err
    );

endinterface

// File: rtl/pixel_frame_ram.sv
// rtl/pixel_frame_ram.sv - simple dual-port frame buffer, 1-cycle read
// Purpose : one image worth of pixels; synchronous write port and a
//           synchronous read port with one cycle of latency. No reset, so
//           contents survive reset and repeated frames.
// Ports   : clk; we/waddr/wdata write port; raddr in, rdata out (registered)
module pixel_frame_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/image_stream_tx.sv
// rtl/image_stream_tx.sv - frame-buffered gap-free pixel transmitter
// Purpose : host loads an image into the frame buffer while idle, then a go
//           pulse sends start_signal followed by every pixel row-major, one
//           per cycle with pixel_valid_in held high, then a frame_done pulse.
// Ports   : clk, rst (synchronous, active high)
//           bus (slave): wr_en/wr_addr/wr_data/go in;
//           start_signal/pixel_valid_in/pixel_in/busy/frame_done/wr_err out
module image_stream_tx
    import npu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    image_stream_tx_if.slave   bus
);

    tx_state_t         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic start_q,  start_d;
    logic valid_q,  valid_d;
    logic busy_q,   busy_d;
    logic done_q,   done_d;
    logic wr_err_q, wr_err_d;

    logic              last_pix;
    logic              wr_ok;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;

    assign last_pix = (idx_q == ADDR_W'(NPIX - 1));

    // Writes land only while idle so a frame in flight never sees a torn
    // image; a write in the same cycle as go still commits before the
    // first read.
    assign wr_ok = bus.wr_en && (state_q == IDLE) && addr_in_range(bus.wr_addr);

    // The RAM read port registers its output, so the address leads the
    // pixel on the wire by one cycle: START fetches pixel 0, and while
    // pixel idx is on the wire, idx+1 is fetched.
    always_comb begin
        rd_addr = '0;
        if (state_q == STREAM) begin
            rd_addr = idx_q + ADDR_W'(1);
        end
    end

    pixel_frame_ram #(
        .DEPTH (NPIX),
        .AW    (ADDR_W),
        .DW    (PIX_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic. go is only looked at in IDLE, so requests during a
    // frame are dropped rather than queued.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = STREAM;
                idx_d   = '0;
            end
            STREAM: begin
                if (last_pix) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so every status output comes
    // straight off a flop in the same cycle the state is entered.
    always_comb begin
        start_d  = (state_d == START);
        valid_d  = (state_d == STREAM);
        done_d   = (state_d == DONE);
        busy_d   = (state_d != IDLE);
        wr_err_d = bus.wr_en && !wr_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            start_q  <= start_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign bus.start_signal   = start_q;
    assign bus.pixel_valid_in = valid_q;
    assign bus.busy           = busy_q;
    assign bus.frame_done     = done_q;
    assign bus.wr_err         = wr_err_q;
    // The RAM output register has no reset, so it is qualified by the
    // registered valid to keep pixel_in at zero outside a frame.
    assign bus.pixel_in       = valid_q ? rd_data : '0;

endmodule
